// File: rtl/pwm_update_sched_pkg.sv
// Shared definitions for the PWM update scheduler: register map,
// CTRL field layout and FSM encodings.
package pwm_update_sched_pkg;

    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_COMMIT = 'h04;
    localparam int OFF_STATUS = 'h08;
    localparam int OFF_CH0    = 'h10;
    localparam int OFF_DUTY   = 'h04;
    localparam int CH_STRIDE  = 8;

    localparam int CTRL_RUN_LSB = 0;
    localparam int CTRL_IE_LSB  = 8;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_e;

    // Expands Wishbone byte selects into a per-bit write mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_update_sched_ch_shadow.sv
// One PWM channel: shadow period/duty, active period/duty and the
// ARMED handshake that moves shadows into the active registers.
module pwm_ch_shadow
    import pwm_update_sched_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [CW-1:0] wdata_i,
    input  logic [CW-1:0] bmask_i,
    input  logic          per_we_i,
    input  logic          duty_we_i,
    input  logic          commit_i,
    input  logic          run_i,
    input  logic          wrap_i,
    output logic          armed_o,
    output logic          load_o,
    output logic [CW-1:0] per_sh_o,
    output logic [CW-1:0] duty_sh_o,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] duty_o
);

    ch_state_e     state_q, state_d;
    logic [CW-1:0] per_sh_q, per_sh_d;
    logic [CW-1:0] duty_sh_q, duty_sh_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CH_IDLE;
            per_sh_q  <= '0;
            duty_sh_q <= '0;
            period_q  <= '0;
            duty_q    <= '0;
        end else begin
            state_q   <= state_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
        end
    end

    // A stopped channel has no wrap to wait for, so it loads at once.
    assign load = (state_q == CH_ARMED) && (!run_i || wrap_i);

    always_comb begin
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        period_d  = period_q;
        duty_d    = duty_q;
        state_d   = state_q;
        if (per_we_i) begin
            per_sh_d = (per_sh_q & ~bmask_i) | (wdata_i & bmask_i);
        end
        if (duty_we_i) begin
            duty_sh_d = (duty_sh_q & ~bmask_i) | (wdata_i & bmask_i);
        end
        if (load) begin
            period_d = per_sh_q;
            duty_d   = (duty_sh_q > per_sh_q) ? per_sh_q : duty_sh_q;
        end
        unique case (state_q)
            CH_IDLE:  if (commit_i) state_d = CH_ARMED;
            CH_ARMED: if (load && !commit_i) state_d = CH_IDLE;
            default:  state_d = CH_IDLE;
        endcase
    end

    assign armed_o   = (state_q == CH_ARMED);
    assign load_o    = load;
    assign per_sh_o  = per_sh_q;
    assign duty_sh_o = duty_sh_q;
    assign period_o  = period_q;
    assign duty_o    = duty_q;

endmodule

// File: rtl/pwm_update_sched.sv
// Wishbone register block that stages PWM period/duty updates and
// commits them glitch-free at each channel's period boundary.
module pwm_update_sched
    import pwm_update_sched_pkg::*;
#(
    parameter int          NCH  = 4,
    parameter int          CW   = 16,
    parameter logic [31:0] BASE = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                resetb,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NCH-1:0]      pwm_wrap_i,
    output logic [NCH-1:0]      pwm_en_o,
    output logic [NCH*CW-1:0]   pwm_period_o,
    output logic [NCH*CW-1:0]   pwm_duty_o,
    output logic                irq_o
);

    bus_state_e     bus_q, bus_d;
    logic [NCH-1:0] run_q, run_d;
    logic [NCH-1:0] ie_q, ie_d;
    logic [NCH-1:0] done_q, done_d;
    logic           irq_q;

    logic [31:0]    off;
    logic [31:0]    bmask;
    logic [31:0]    ctrl_word;
    logic [31:0]    rdata;
    logic           ack;
    logic           wr_en;
    logic           hit_ctrl, hit_commit, hit_status;
    logic [NCH-1:0] per_hit, duty_hit;
    logic [NCH-1:0] commit_vec, clr_vec;
    logic [NCH-1:0] armed_vec, load_vec;
    logic [CW-1:0]  per_sh  [NCH];
    logic [CW-1:0]  duty_sh [NCH];
    logic           unused_bits;

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            bus_q  <= BUS_IDLE;
            run_q  <= '0;
            ie_q   <= '0;
            done_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            bus_q  <= bus_d;
            run_q  <= run_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            irq_q  <= |(done_q & ie_q);
        end
    end

    always_comb begin
        bus_d = bus_q;
        unique case (bus_q)
            BUS_IDLE: if (wbs_cyc_i && wbs_stb_i) bus_d = BUS_ACK;
            BUS_ACK:  bus_d = BUS_IDLE;
            default:  bus_d = BUS_IDLE;
        endcase
    end

    assign ack   = (bus_q == BUS_ACK);
    assign wr_en = ack && wbs_cyc_i && wbs_stb_i && wbs_we_i;
    assign off   = wbs_adr_i - BASE;
    assign bmask = sel_to_mask(wbs_sel_i);

    always_comb begin
        hit_ctrl   = (off == 32'(OFF_CTRL));
        hit_commit = (off == 32'(OFF_COMMIT));
        hit_status = (off == 32'(OFF_STATUS));
        per_hit    = '0;
        duty_hit   = '0;
        for (int i = 0; i < NCH; i++) begin
            per_hit[i]  = (off == 32'(OFF_CH0 + CH_STRIDE*i));
            duty_hit[i] = (off == 32'(OFF_CH0 + CH_STRIDE*i + OFF_DUTY));
        end
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_RUN_LSB +: NCH] = run_q;
        ctrl_word[CTRL_IE_LSB +: NCH]  = ie_q;
        run_d = run_q;
        ie_d  = ie_q;
        if (wr_en && hit_ctrl) begin
            run_d = (run_q & ~bmask[CTRL_RUN_LSB +: NCH])
                  | (wbs_dat_i[CTRL_RUN_LSB +: NCH] & bmask[CTRL_RUN_LSB +: NCH]);
            ie_d  = (ie_q & ~bmask[CTRL_IE_LSB +: NCH])
                  | (wbs_dat_i[CTRL_IE_LSB +: NCH] & bmask[CTRL_IE_LSB +: NCH]);
        end
        commit_vec = '0;
        clr_vec    = '0;
        if (wr_en && hit_commit) commit_vec = wbs_dat_i[NCH-1:0] & bmask[NCH-1:0];
        if (wr_en && hit_status) clr_vec = wbs_dat_i[NCH-1:0] & bmask[NCH-1:0];
        // A done set on the same edge as its clear must survive.
        done_d = (done_q & ~clr_vec) | load_vec;
    end

    always_comb begin
        rdata = '0;
        if (hit_ctrl) begin
            rdata = ctrl_word;
        end else if (hit_commit) begin
            rdata[NCH-1:0] = armed_vec;
        end else if (hit_status) begin
            rdata[NCH-1:0] = done_q;
        end
        for (int i = 0; i < NCH; i++) begin
            if (per_hit[i])  rdata = 32'(per_sh[i]);
            if (duty_hit[i]) rdata = 32'(duty_sh[i]);
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = (ack && !wbs_we_i) ? rdata : '0;
    assign irq_o     = irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_ch_shadow #(.CW(CW)) u_ch (
            .clk_i     (wb_clk_i),
            .rst_ni    (resetb),
            .wdata_i   (wbs_dat_i[CW-1:0]),
            .bmask_i   (bmask[CW-1:0]),
            .per_we_i  (wr_en & per_hit[g]),
            .duty_we_i (wr_en & duty_hit[g]),
            .commit_i  (commit_vec[g]),
            .run_i     (run_q[g]),
            .wrap_i    (pwm_wrap_i[g]),
            .armed_o   (armed_vec[g]),
            .load_o    (load_vec[g]),
            .per_sh_o  (per_sh[g]),
            .duty_sh_o (duty_sh[g]),
            .period_o  (pwm_period_o[g*CW +: CW]),
            .duty_o    (pwm_duty_o[g*CW +: CW])
        );
        assign pwm_en_o[g] = run_q[g] & (pwm_period_o[g*CW +: CW] != '0);
    end

    assign unused_bits = ^{wbs_dat_i, bmask};

endmodule
